// File: rtl/adel2_pkg.sv
// adel2_pkg: instruction class/op encodings, FSM states and instruction field positions for adel2_core.
package adel2_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;
  typedef enum logic [1:0] {BR_EQZ, BR_NEZ, BR_LTZ, BR_GTZ} br_cond_e;
  typedef enum logic [1:0] {SYS_LD, SYS_ST, SYS_LDIH, SYS_HALT} sys_op_e;
  typedef enum logic [1:0] {RUN, MEM, HALT} state_e;
  localparam int CLS_BIT = 15;
  localparam int OP_HI   = 14;
  localparam int OP_LO   = 13;
  localparam int SEL_BIT = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RS1_HI  = 9;
  localparam int RS1_LO  = 8;
  localparam int RS2_HI  = 1;
  localparam int RS2_LO  = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
endpackage

// File: rtl/adel2_alu.sv
// adel2_alu: combinational ALU result and signed branch-condition flag on operand a.
module adel2_alu
  import adel2_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        op,
  input  logic [1:0]        cond,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              taken
);
  always_comb begin
    y = op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : op == ALU_AND ? a & b : a | b;
    taken = cond == BR_EQZ ? a == '0 :
            cond == BR_NEZ ? a != '0 :
            cond == BR_LTZ ? a[DATA_W-1] : !a[DATA_W-1] && a != '0;
  end
endmodule

// File: rtl/adel2_core.sv
// adel2_core: 4-register load/store core with fetch handshake, valid/ready data port and HALT.
// Define ADEL2_RETIRE_CNT_EN to add the 32-bit retire_cnt port and counter.
module adel2_core
  import adel2_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [15:0]       inst,
  input  logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted
`ifdef ADEL2_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);
  state_e            state, state_d;
  logic [DATA_W-1:0] regs [4];
  logic [1:0]        rd, rs1, rs2, mem_rd, wr_idx;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] a, imm_z, ea, alu_y, wr_data;
  logic [PC_W-1:0]   pc_d;
  logic              taken, fire, mem_done, is_alu, is_br, is_mem, is_ldih, is_halt, wr_en;
  sys_op_e           sop;

  assign rd       = inst[RD_HI:RD_LO];
  assign rs1      = inst[RS1_HI:RS1_LO];
  assign rs2      = inst[RS2_HI:RS2_LO];
  assign imm8     = inst[IMM_HI:IMM_LO];
  assign sop      = sys_op_e'(inst[OP_HI:OP_LO]);
  assign a        = regs[rs1];
  assign imm_z    = DATA_W'(imm8);
  assign ea       = a + imm_z;
  assign fire     = state == RUN && inst_valid;
  assign mem_done = state == MEM && dmem_ready;
  assign is_alu   = inst[CLS_BIT];
  assign is_br    = !inst[CLS_BIT] && !inst[SEL_BIT];
  assign is_mem   = !inst[CLS_BIT] && inst[SEL_BIT] && (sop == SYS_LD || sop == SYS_ST);
  assign is_ldih  = !inst[CLS_BIT] && inst[SEL_BIT] && sop == SYS_LDIH;
  assign is_halt  = !inst[CLS_BIT] && inst[SEL_BIT] && sop == SYS_HALT;
  assign halted   = state == HALT;

  adel2_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (inst[OP_HI:OP_LO]),
    .cond (inst[OP_HI:OP_LO]),
    .a    (a),
    .b    (inst[SEL_BIT] ? regs[rs2] : imm_z),
    .y    (alu_y),
    .taken(taken)
  );

  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    wr_idx  = rd;
    wr_data = alu_y;
    pc_d    = pc;
    if (mem_done) begin
      state_d = RUN;
      wr_en   = !dmem_we;
      wr_idx  = mem_rd;
      wr_data = dmem_rdata;
      pc_d    = pc + PC_W'(1);
    end else if (fire) begin
      state_d = is_mem ? MEM : is_halt ? HALT : RUN;
      wr_en   = is_alu || is_ldih;
      wr_data = is_alu ? alu_y : {regs[rd][DATA_W-9:0], imm8};
      pc_d    = is_br && taken ? pc + PC_W'($signed(imm8)) : is_mem || is_halt ? pc : pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= RUN;
    else state <= state_d;

  // Load/store request fields are captured at acceptance so they stay stable while waiting.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      pc         <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mem_rd     <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      pc <= pc_d;
      if (wr_en) regs[wr_idx] <= wr_data;
      if (fire && is_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= sop == SYS_ST;
        dmem_addr  <= ADDR_W'(ea);
        dmem_wdata <= regs[rd];
        mem_rd     <= rd;
      end else if (mem_done) dmem_req <= 1'b0;
    end

`ifdef ADEL2_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) retire_cnt <= '0;
    else if ((fire && !is_mem) || mem_done) retire_cnt <= retire_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_adel2_core.sv
// tb_adel2_core: table-driven program run with a data-memory scoreboard, plus reset-mid-access and HALT sequences.
module tb_adel2_core;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic [15:0] pc;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        halted;
`ifdef ADEL2_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  adel2_core dut (
    .clk(clk), .nrst(nrst), .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted)
`ifdef ADEL2_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inst;
    logic        valid;
    logic        mem;
    int          waits;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        cw;
  } sb_t;

  sb_t  q[$];
  vec_t tbl[21];
  int   checks = 0;
  int   failures = 0;
  int   exp_ret = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (nrst && dmem_req) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_req actual addr=%0h required no request", dmem_addr);
      end else begin
        chk("sb_we", dmem_we, q[0].we);
        chk("sb_addr", dmem_addr, q[0].addr);
        if (q[0].cw) chk("sb_wdata", dmem_wdata, q[0].wdata);
        if (dmem_ready) void'(q.pop_front());
      end
    end

  task automatic do_mem(input vec_t v);
    int n;
    q.push_back('{v.we, v.addr, v.wdata, v.we});
    inst = v.inst;
    inst_valid = 1'b1;
    dmem_ready = 1'b0;
    tick();
    chk("mem_req_rise", dmem_req, 1);
    inst = 16'h7000;
    n = 0;
    while (dmem_req && n < 64) begin
      chk("mem_pc_frozen", pc, v.exp_pc - 16'd1);
      dmem_ready = n == v.waits;
      dmem_rdata = v.rdata;
      tick();
      n++;
    end
    inst_valid = 1'b0;
    dmem_ready = 1'b0;
    chk("mem_latency", n, v.waits + 1);
    chk("mem_pc_next", pc, v.exp_pc);
  endtask

  initial begin
    tbl[0]  = '{16'h8405, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0001};
    tbl[1]  = '{16'hB901, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0002};
    tbl[2]  = '{16'h5C12, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0003};
    tbl[3]  = '{16'h5C34, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0004};
    tbl[4]  = '{16'h00FE, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0002};
    tbl[5]  = '{16'h3408, 1, 1, 0, 1, 16'h8, 16'h5, 16'h0, 16'h0003};
    tbl[6]  = '{16'h3809, 1, 1, 0, 1, 16'h9, 16'h0, 16'h0, 16'h0004};
    tbl[7]  = '{16'hAA01, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0005};
    tbl[8]  = '{16'h6205, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0006};
    tbl[9]  = '{16'h4203, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0009};
    tbl[10] = '{16'h2009, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h000A};
    tbl[11] = '{16'hE530, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h000B};
    tbl[12] = '{16'hC50F, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h000C};
    tbl[13] = '{16'h0080, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'hFF8C};
    tbl[14] = '{16'h0074, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0000};
    tbl[15] = '{16'h8405, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0000};
    tbl[16] = '{16'h3C07, 1, 1, 3, 1, 16'h7, 16'h1234, 16'h0, 16'h0001};
    tbl[17] = '{16'h3408, 1, 1, 0, 1, 16'h8, 16'h0005, 16'h0, 16'h0002};
    tbl[18] = '{16'h1407, 1, 1, 0, 0, 16'h7, 16'h0, 16'hBEEF, 16'h0003};
    tbl[19] = '{16'h3408, 1, 1, 0, 1, 16'h8, 16'hBEEF, 16'h0, 16'h0004};
    tbl[20] = '{16'h3A02, 1, 1, 1, 1, 16'h1, 16'hFFFF, 16'h0, 16'h0005};

    tick();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_halted", halted, 0);
`ifdef ADEL2_RETIRE_CNT_EN
    chk("rst_retire", retire_cnt, 0);
`endif
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].valid) exp_ret++;
      if (tbl[i].mem) do_mem(tbl[i]);
      else begin
        inst = tbl[i].inst;
        inst_valid = tbl[i].valid;
        tick();
        inst_valid = 1'b0;
        chk($sformatf("pc_vec%0d", i), pc, tbl[i].exp_pc);
      end
    end
    dmem_ready = 1'b1;
    tick();
    chk("ready_idle_req", dmem_req, 0);
    chk("ready_idle_pc", pc, 16'h0005);
    dmem_ready = 1'b0;
`ifdef ADEL2_RETIRE_CNT_EN
    chk("retire_prog", retire_cnt, exp_ret);
`endif

    q.push_back('{1'b1, 16'h7, 16'h1234, 1'b1});
    inst = 16'h3C07;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("rstmem_req", dmem_req, 1);
    tick();
    nrst = 1'b0;
    #1;
    chk("rstmem_req_drop", dmem_req, 0);
    chk("rstmem_pc", pc, 0);
    q.delete();
    tick();
    nrst = 1'b1;
    chk("rstmem_we", dmem_we, 0);
    chk("rstmem_addr", dmem_addr, 0);
    chk("rstmem_wdata", dmem_wdata, 0);
    tick();

    inst = 16'h8405;
    inst_valid = 1'b1;
    tick();
    chk("halt_pre_pc", pc, 1);
    inst = 16'h7000;
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 1);
    inst = 16'h8405;
    dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_pc_frozen", pc, 1);
      chk("halt_stays", halted, 1);
      chk("halt_no_req", dmem_req, 0);
    end
    inst_valid = 1'b0;
    dmem_ready = 1'b0;
`ifdef ADEL2_RETIRE_CNT_EN
    chk("retire_halt", retire_cnt, 2);
`endif
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adel2_core.md
# adel2_core

Parametrised second-generation adel core: a 4-register load/store processor that executes a fixed 16-bit instruction stream at a configurable data and address width. It adds three things: an instruction-valid fetch handshake, a valid/ready data-memory port for loads and stores, and a HALT state. The core sits between the instruction ROM/scan interface and the shared data SRAM wrapper in the demo SoC.

## Interface
- DATA_W, 16, register/ALU/data width; legal range 9..32.
- PC_W, 16, program counter width.
- ADDR_W, 16, data-memory word address width.
- clk  in  1  core clock.
- nrst  in  1  asynchronous active-low reset.
- inst  in  16  instruction at address pc.
- inst_valid  in  1  inst is valid this cycle.
- pc  out  PC_W  fetch address.
- dmem_req  out  1  data request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  word address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ready  in  1  request accepted/completed this cycle.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1.
- halted  out  1  core is in HALT.
- retire_cnt  out  32  retired-instruction count (only with ADEL2_RETIRE_CNT_EN).

## Operation
- One clock, clk; reset nrst is asynchronous and active-low.
- Register file: r0..r3, DATA_W bits each, all writable, signed for comparisons.
- Instruction fields: rd=inst[11:10], rs1=inst[9:8], rs2=inst[1:0], imm8=inst[7:0].
- ALU class, inst[15]=1:
  - op=inst[14:13]: 00 ADD, 01 SUB, 10 AND, 11 OR.
  - Operand 2 is rs2 when inst[12]=1, else imm8 zero-extended.
  - Result is rd <= rs1 op op2, mod 2^DATA_W.
- Branch class, inst[15]=0, inst[12]=0:
  - cond=inst[14:13] tests rs1: 00 ==0, 01 !=0, 10 <0, 11 >0 (signed).
  - Taken: pc <= pc + sext(imm8), mod 2^PC_W. Not taken: pc <= pc+1.
- System class, inst[15]=0, inst[12]=1, op=inst[14:13]:
  - 00 LD: rd <= mem[rs1 + zext(imm8)].
  - 01 ST: mem[rs1 + zext(imm8)] <= rd.
  - 10 LDIH: rd <= {rd[DATA_W-9:0], imm8}, shifts the immediate in from the bottom.
  - 11 HALT.
  - Memory address is truncated to ADDR_W.
- FSM states:
  - RUN, the reset state. With inst_valid=1 it executes one instruction: ALU, branch and LDIH complete in that cycle. LD/ST latch addr/we/wdata/rd and go to MEM. HALT goes to HALT. With inst_valid=0, nothing changes.
  - MEM: dmem_req=1 and addr/we/wdata are held stable. inst and inst_valid are ignored and pc is frozen. On dmem_ready=1, an LD writes rd from dmem_rdata, pc <= pc+1, and the core returns to RUN.
  - HALT: halted=1 and pc is frozen with no further execution. Only nrst exits this state.
- pc after HALT: pc holds the HALT instruction address.

## Timing
- Reset values:
  - pc=0, r0..r3=0, state RUN.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - halted=0, retire_cnt=0.
- Single-cycle instructions: rd and pc update on the accepting edge.
- dmem outputs are registered. dmem_req rises the cycle after LD/ST acceptance.
- Minimum LD/ST latency is 2 cycles when dmem_ready=1 in the first MEM cycle.
- Each dmem_ready cycle while waiting adds 0; each dmem_ready=0 cycle adds 1.
- dmem_ready while dmem_req=0 is ignored.
- dmem_req deasserts on the edge at which dmem_ready=1 was sampled, so there are no back-to-back requests without an intervening RUN cycle.
- Reading a register written by the previous instruction returns the new value, because writes complete before the next acceptance.
- Reset asserted mid-MEM drops dmem_req asynchronously and the pending access is abandoned.

## Configuration
- ADEL2_RETIRE_CNT_EN defined:
  - retire_cnt is a 32-bit wrapping counter incremented once per retired instruction.
  - Retire points: ALU, branch and LDIH at acceptance; LD/ST at dmem_ready; HALT at acceptance.
- ADEL2_RETIRE_CNT_EN undefined: the retire_cnt port and counter are absent.

## Structure
- adel2_pkg holds:
  - the class/op enums (alu_op_e, br_cond_e, sys_op_e);
  - the state enum (RUN, MEM, HALT);
  - localparams for field bit positions.
- Sub-module adel2_alu (combinational) computes the ALU result and the branch condition flag for a given DATA_W.

## Test plan
- Reset, then ADD imm r1=r0+5, SUB r2=r1-r1 -> r1=5, r2=0, pc=2.
- r0=0; BEQ r0 off=-2 at pc=4 -> pc=2. BGT with r=-1 -> not taken, pc=pc+1.
- LDIH r3 with 0x12 then 0x34 (DATA_W=16) -> r3=0x1234.
- ST r3 at r0+7 with dmem_ready low 3 cycles -> dmem_req held 4 cycles, addr=7, wdata=0x1234, pc frozen, then pc+1.
- LD r1 at 7 with ready=1 immediately, rdata=0xBEEF -> r1=0xBEEF after 2 cycles. Reset asserted mid-MEM -> dmem_req=0 at once.
- HALT -> halted=1, pc frozen despite inst_valid. retire_cnt equals the count of retired instructions, HALT included, when the macro is defined.
